// File: rtl/ccff_pkg.sv
// Shared state encoding and sizing helpers for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } ccff_state_e;

    // Bits of the final word of a pass that actually reach the chain.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        int rem;
        rem = chain_len % word_w;
        return (rem == 0) ? word_w : rem;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serialiser (holding word + shift word, MSB first); a word accepted in cycle N offers its first bit in N+1.
// Backpressure: wd_ready drops while the holding word is occupied or load is low.
module ccff_word_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              wd_valid,
    input  logic [WORD_W-1:0] wd_data,
    output logic              wd_ready,
    input  logic              pop,
    input  logic              pop_last,
    output logic              bit_dat,
    output logic              bit_avail
);

    localparam int LW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] hold;
    logic [LW-1:0]     sh_left;
    logic              hold_vld;
    logic              accept;
    logic              word_end;
    logic              slot_free;

    assign wd_ready  = load & ~hold_vld;
    assign accept    = wd_valid & wd_ready;
    assign bit_avail = (sh_left != '0);
    assign bit_dat   = shreg[WORD_W-1];
    // pop_last truncates a partial final word; its unsent low bits are dropped here.
    assign word_end  = pop & (pop_last | (sh_left == LW'(1)));
    assign slot_free = word_end | ~bit_avail;

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            hold     <= '0;
            sh_left  <= '0;
            hold_vld <= 1'b0;
        end else if (flush) begin
            shreg    <= '0;
            hold     <= '0;
            sh_left  <= '0;
            hold_vld <= 1'b0;
        end else if (slot_free) begin
            if (hold_vld) begin
                shreg    <= hold;
                sh_left  <= LW'(WORD_W);
                hold_vld <= 1'b0;
            end else if (accept) begin
                shreg   <= wd_data;
                sh_left <= LW'(WORD_W);
            end else begin
                sh_left <= '0;
            end
        end else begin
            if (pop) begin
                shreg   <= shreg << 1;
                sh_left <= sh_left - LW'(1);
            end
            if (accept) begin
                hold     <= wd_data;
                hold_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads (and optionally read-back verifies) a tile-column config chain; first shift one cycle after first word accept.
// Backpressure: wd_ready follows the serialiser holding word while busy; underflow simply pauses shift_en.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic              wd_valid,
    input  logic [WORD_W-1:0] wd_data,
    output logic              wd_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_bit
);

    import ccff_pkg::*;

    localparam bit              PARTIAL  = (last_word_bits(CHAIN_LEN, WORD_W) != WORD_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    ccff_state_e      state;
    ccff_state_e      state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             verify_q;
    logic             head_q;
    logic             bit_dat;
    logic             bit_avail;
    logic             last_bit;
    logic             start_go;

    assign busy      = (state == LOAD) || (state == VERIFY);
    assign done      = (state == DONE);
    assign shift_en  = busy & bit_avail & ~abort;
    assign last_bit  = (bit_cnt == LAST_IDX);
    assign ccff_head = shift_en ? bit_dat : head_q;
    assign start_go  = (state == IDLE) & start & ~abort;

    // Buffers stay intact across LOAD->VERIFY so the re-sent stream flows without a gap.
    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk  (prog_clk),
        .reset     (reset),
        .flush     (~busy | abort),
        .load      (busy),
        .wd_valid  (wd_valid),
        .wd_data   (wd_data),
        .wd_ready  (wd_ready),
        .pop       (shift_en),
        .pop_last  (PARTIAL & last_bit),
        .bit_dat   (bit_dat),
        .bit_avail (bit_avail)
    );

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    if (shift_en && last_bit) state_nxt = verify_q ? VERIFY : DONE;
                VERIFY:  if (shift_en && last_bit) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            verify_q <= 1'b0;
            head_q   <= 1'b0;
            error    <= 1'b0;
            err_bit  <= '0;
        end else begin
            state  <= state_nxt;
            head_q <= ccff_head;
            if (start_go) begin
                verify_q <= verify_en;
                error    <= 1'b0;
                err_bit  <= '0;
                bit_cnt  <= '0;
            end else if (abort) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                // The chain is FIFO-ordered: the bit leaving it must equal the bit re-entering it.
                if ((state == VERIFY) && (ccff_tail != bit_dat) && !error) begin
                    error   <= 1'b1;
                    err_bit <= bit_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic        rst_n, start64, start40, verify_en, abort, wd_valid;
    logic [31:0] wd_data;
    logic        tail64;
    logic        rdy64, head64, sh64, busy64, done64, err64;
    logic [15:0] eb64;
    logic        rdy40, head40, sh40, busy40, done40, err40;
    logic [15:0] eb40;

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(32), .CNT_W(16)) u_dut64 (
        .prog_clk(prog_clk), .reset(rst_n), .start(start64), .verify_en(verify_en),
        .abort(abort), .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(rdy64),
        .ccff_head(head64), .ccff_tail(tail64), .shift_en(sh64), .busy(busy64),
        .done(done64), .error(err64), .err_bit(eb64)
    );

    ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32), .CNT_W(16)) u_dut40 (
        .prog_clk(prog_clk), .reset(rst_n), .start(start40), .verify_en(verify_en),
        .abort(abort), .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(rdy40),
        .ccff_head(head40), .ccff_tail(1'b0), .shift_en(sh40), .busy(busy40),
        .done(done40), .error(err40), .err_bit(eb40)
    );

    // 64-bit chain model; optionally corrupts the tail at one VERIFY index
    logic [63:0] chain = '0;
    int          shcnt64 = 0;
    bit          flip_en = 1'b0;
    int          flip_idx = 37;
    always @(posedge prog_clk) begin
        if (start64) shcnt64 <= 0;
        else if (sh64) begin
            chain   <= {chain[62:0], head64};
            shcnt64 <= shcnt64 + 1;
        end
    end
    assign tail64 = chain[63] ^ (flip_en && (shcnt64 == 64 + flip_idx));

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    int   npass = 0, ntotal = 0;
    int   nshift, done_cnt, first_shift_cyc, last_shift_cyc, acc_cyc;
    bit   prev_shift, first_pending, sel;
    logic exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic cur_rdy();
        return sel ? rdy40 : rdy64;
    endfunction

    task automatic mon_loop();
        logic s, h, d, e;
        forever begin
            @(negedge prog_clk);
            if (start64 || start40) begin
                nshift = 0; done_cnt = 0; prev_shift = 1'b0;
            end else begin
                s = sel ? sh40 : sh64;
                h = sel ? head40 : head64;
                d = sel ? done40 : done64;
                if (s) begin
                    if (nshift == 0) first_shift_cyc = cyc;
                    last_shift_cyc = cyc;
                    nshift++;
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                    chk("ccff_head", 32'(h), 32'(e));
                end
                if (d) begin
                    done_cnt++;
                    chk("done_after_last_shift", 32'({prev_shift, exp_q.size() == 0}), 32'b11);
                end
                prev_shift = s;
            end
        end
    endtask

    task automatic do_start(input bit s40, input bit ver);
        start64 = ~s40; start40 = s40; verify_en = ver;
        @(posedge prog_clk); #1;
        start64 = 1'b0; start40 = 1'b0;
        first_pending = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] d, input int nb);
        int t;
        t = 0;
        wd_valid = 1'b1; wd_data = d;
        @(negedge prog_clk);
        while (!cur_rdy() && t < 200) begin @(negedge prog_clk); t++; end
        chk("wd_ready", 32'(cur_rdy()), 32'd1);
        if (cur_rdy()) begin
            if (first_pending) begin acc_cyc = cyc; first_pending = 1'b0; end
            for (int i = 0; i < nb; i++) exp_q.push_back(d[31-i]);
        end
        @(posedge prog_clk); #1;
        wd_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge prog_clk);
        #1;
    endtask

    task automatic wait_shifts(input int n);
        int t;
        t = 0;
        while (nshift != n && t < 200) begin @(posedge prog_clk); #1; t++; end
        chk("reach_shift_count", 32'(nshift), 32'(n));
    endtask

    task automatic run_basic(input string tag);
        sel = 1'b0;
        do_start(1'b0, 1'b0);
        send_word(32'hA5A5A5A5, 32);
        send_word(32'h0F0F0F0F, 32);
        settle(70);
        chk({tag, "_nshift"}, 32'(nshift), 32'd64);
        chk({tag, "_span"}, 32'(last_shift_cyc - first_shift_cyc + 1), 32'd64);
        chk({tag, "_latency"}, 32'(first_shift_cyc - acc_cyc), 32'd1);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_error"}, 32'(err64), 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start64 = 1'b0; start40 = 1'b0; verify_en = 1'b0;
        abort = 1'b0; wd_valid = 1'b0; wd_data = '0; sel = 1'b0;
        nshift = 0; done_cnt = 0; first_shift_cyc = 0; last_shift_cyc = 0;
        acc_cyc = 0; prev_shift = 1'b0; first_pending = 1'b0;
        fork mon_loop(); join_none

        settle(3);
        chk("rst_busy", 32'({busy64, busy40}), 32'd0);
        chk("rst_shift_en", 32'({sh64, sh40}), 32'd0);
        chk("rst_wd_ready", 32'({rdy64, rdy40}), 32'd0);
        chk("rst_done", 32'({done64, done40}), 32'd0);
        chk("rst_error", 32'({err64, err40}), 32'd0);
        chk("rst_err_bit", 32'({eb64, eb40}), 32'd0);
        chk("rst_head", 32'({head64, head40}), 32'd0);
        rst_n = 1'b1;
        settle(1);

        // back-to-back load, no verify
        run_basic("load64");

        // partial final word, run twice to see wrap and flush
        for (int rep = 0; rep < 2; rep++) begin
            sel = 1'b1;
            do_start(1'b1, 1'b0);
            send_word(32'hFFFFFFFF, 32);
            send_word(32'h12345678, 8);
            settle(50);
            chk("load40_nshift", 32'(nshift), 32'd40);
            chk("load40_done_cnt", 32'(done_cnt), 32'd1);
            chk("load40_idle_ready", 32'(rdy40), 32'd0);
            chk("load40_queue_empty", 32'(exp_q.size()), 32'd0);
        end
        sel = 1'b0;

        // load + verify, clean then with a corrupted tail bit
        for (int f = 0; f < 2; f++) begin
            flip_en = (f == 1);
            do_start(1'b0, 1'b1);
            send_word(32'hA5A5A5A5, 32);
            send_word(32'h0F0F0F0F, 32);
            send_word(32'hA5A5A5A5, 32);
            send_word(32'h0F0F0F0F, 32);
            settle(70);
            chk("verify_nshift", 32'(nshift), 32'd128);
            chk("verify_done_cnt", 32'(done_cnt), 32'd1);
            chk("verify_error", 32'(err64), (f == 1) ? 32'd1 : 32'd0);
            chk("verify_err_bit", 32'(eb64), (f == 1) ? 32'd37 : 32'd0);
        end
        flip_en = 1'b0;

        // gapped words: source waits for the chain to drain, then 3 more cycles
        do_start(1'b0, 1'b0);
        chk("error_cleared_by_start", 32'(err64), 32'd0);
        send_word(32'hC3C3C3C3, 32);
        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin @(posedge prog_clk); #1; t++; end
        end
        settle(3);
        send_word(32'h5A0FF0A5, 32);
        settle(40);
        chk("gap_nshift", 32'(nshift), 32'd64);
        chk("gap_span", 32'(last_shift_cyc - first_shift_cyc + 1), 32'd68);
        chk("gap_done_cnt", 32'(done_cnt), 32'd1);

        // reset mid-pass
        do_start(1'b0, 1'b0);
        send_word(32'hA5A5A5A5, 32);
        send_word(32'h0F0F0F0F, 32);
        wait_shifts(20);
        chk("pre_reset_shift_en", 32'(sh64), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_shift_en_same_cycle", 32'(sh64), 32'd0);
        chk("reset_busy", 32'(busy64), 32'd0);
        exp_q.delete();
        @(posedge prog_clk); #1;
        rst_n = 1'b1;
        settle(5);
        chk("reset_no_done", 32'(done_cnt), 32'd0);
        chk("reset_shift_stopped", 32'(nshift), 32'd20);
        run_basic("after_reset");

        // abort mid-pass
        do_start(1'b0, 1'b0);
        send_word(32'hA5A5A5A5, 32);
        send_word(32'h0F0F0F0F, 32);
        wait_shifts(20);
        abort = 1'b1;
        #1;
        chk("abort_shift_en_same_cycle", 32'(sh64), 32'd0);
        @(posedge prog_clk); #1;
        abort = 1'b0;
        chk("abort_shift_en_next_cycle", 32'(sh64), 32'd0);
        chk("abort_busy", 32'(busy64), 32'd0);
        exp_q.delete();
        settle(5);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_shift_stopped", 32'(nshift), 32'd20);
        run_basic("after_abort");

        // start and abort together in IDLE: abort wins
        start64 = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        start64 = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy64), 32'd0);
        settle(2);
        chk("start_abort_stays_idle", 32'({busy64, done64}), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
